// File: rtl/misr_multi_if.sv
// Bus bundle for the multi-channel MISR: control, per-channel data and results.
interface misr_multi_if #(
    parameter int NUM_BITS = 54,
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16
);
    logic                       i_mode;
    logic                       i_start;
    logic                       i_done;
    logic [NUM_BITS-1:0]        i_seed;
    logic [NUM_CH-1:0]          i_vld;
    logic [NUM_CH*NUM_BITS-1:0] i_data;
    logic [NUM_CH*NUM_BITS-1:0] i_golden;
    logic [NUM_CH*NUM_BITS-1:0] o_sig;
    logic [NUM_CH-1:0]          o_sig_vld;
    logic [NUM_CH*CNT_W-1:0]    o_cnt;
    logic [NUM_CH-1:0]          o_pass;
    logic                       o_all_pass;
    logic                       o_busy;

    modport master (
        output i_mode, i_start, i_done, i_seed, i_vld, i_data, i_golden,
        input  o_sig, o_sig_vld, o_cnt, o_pass, o_all_pass, o_busy
    );

    modport slave (
        input  i_mode, i_start, i_done, i_seed, i_vld, i_data, i_golden,
        output o_sig, o_sig_vld, o_cnt, o_pass, o_all_pass, o_busy
    );
endinterface

// File: rtl/misr_multi.sv
// Multi-channel MISR signature compactor with golden compare and bypass capture.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset; signatures hold, beats ignored
// RUN   | valid beats compress (mode 1) or are captured raw (mode 0)
// HOLD  | result frozen; o_pass / o_all_pass valid until next start
module misr_multi #(
    parameter int                  NUM_BITS = 54,
    parameter int                  NUM_CH   = 4,
    parameter logic [NUM_BITS-1:0] TAP_MASK = 54'h30_0000_0003_0000,
    parameter int                  CNT_W    = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    misr_multi_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_load;
    logic                w_beat;
    logic                w_finish;
    logic                r_busy;

    logic [NUM_BITS-1:0] r_sig   [NUM_CH];
    logic [CNT_W-1:0]    r_cnt   [NUM_CH];
    logic [NUM_BITS-1:0] w_step  [NUM_CH];
    logic [NUM_BITS-1:0] w_upd   [NUM_CH];
    logic [NUM_CH-1:0]   w_fb;
    logic [NUM_CH-1:0]   w_pass_nxt;
    logic [NUM_CH-1:0]   r_sig_vld;
    logic [NUM_CH-1:0]   r_pass;

    // State register; busy is registered alongside so it tracks RUN exactly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_RUN);
        end
    end

    // Next state and datapath strobes; start always wins over done.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_beat      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE, ST_HOLD: begin
                if (bus.i_start) begin
                    w_state_nxt = ST_RUN;
                    w_load      = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.i_start) begin
                    w_load = 1'b1;
                end else begin
                    w_beat = 1'b1;
                    if (bus.i_done) begin
                        w_state_nxt = ST_HOLD;
                        w_finish    = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [NUM_BITS-1:0] w_d;
        assign w_d            = bus.i_data[g*NUM_BITS +: NUM_BITS];
        assign w_fb[g]        = ~(^(r_sig[g] & TAP_MASK));
        assign w_step[g]      = bus.i_mode ? ({r_sig[g][NUM_BITS-2:0], w_fb[g]} ^ w_d) : w_d;
        assign w_upd[g]       = bus.i_vld[g] ? w_step[g] : r_sig[g];
        // Compare against the signature including the final (done-cycle) beat.
        assign w_pass_nxt[g]  = bus.i_mode & (w_upd[g] == bus.i_golden[g*NUM_BITS +: NUM_BITS]);
        assign bus.o_sig[g*NUM_BITS +: NUM_BITS] = r_sig[g];
        assign bus.o_cnt[g*CNT_W +: CNT_W]       = r_cnt[g];
    end

    // Per-channel signature, beat counter, result-valid and pass registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_sig[c] <= bus.i_seed;
                r_cnt[c] <= '0;
            end
            r_sig_vld <= '0;
            r_pass    <= '0;
        end else begin
            r_sig_vld <= '0;
            if (w_load) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_sig[c] <= bus.i_seed;
                    r_cnt[c] <= '0;
                end
                r_pass <= '0;
            end else if (w_beat) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    r_sig[c] <= w_upd[c];
                    if (bus.i_vld[c] && (r_cnt[c] != {CNT_W{1'b1}})) begin
                        r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                    end
                end
                if (!bus.i_mode) begin
                    r_sig_vld <= bus.i_vld;
                end else if (w_finish) begin
                    r_sig_vld <= '1;
                end
                if (w_finish) begin
                    r_pass <= w_pass_nxt;
                end
            end
        end
    end

    assign bus.o_sig_vld  = r_sig_vld;
    assign bus.o_pass     = r_pass;
    assign bus.o_busy     = r_busy;
    assign bus.o_all_pass = (r_state == ST_HOLD) & (&r_pass);

endmodule

// File: tb/tb_misr_multi.sv
// Self-checking bench: a default-size instance driven with random runs against a
// run-level reference model, plus a 4-bit/2-channel instance for hand-derived cases.
module tb_misr_multi;

    localparam int            NB   = 54;
    localparam int            NC   = 4;
    localparam int            CW   = 16;
    localparam logic [NB-1:0] TAP  = 54'h30_0000_0003_0000;
    localparam int            SNB  = 4;
    localparam int            SNC  = 2;
    localparam int            SCW  = 4;
    localparam logic [SNB-1:0] STAP = 4'b1100;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    always #5 clk = ~clk;

    misr_multi_if #(.NUM_BITS(NB),  .NUM_CH(NC),  .CNT_W(CW))  bus_a();
    misr_multi_if #(.NUM_BITS(SNB), .NUM_CH(SNC), .CNT_W(SCW)) bus_b();

    misr_multi #(.NUM_BITS(NB), .NUM_CH(NC), .TAP_MASK(TAP), .CNT_W(CW)) dut_a (
        .i_clk (clk),
        .i_rst (rst_a),
        .bus   (bus_a)
    );

    misr_multi #(.NUM_BITS(SNB), .NUM_CH(SNC), .TAP_MASK(STAP), .CNT_W(SCW)) dut_b (
        .i_clk (clk),
        .i_rst (rst_b),
        .bus   (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference LFSR/bypass step computed from the feedback rule with plain arithmetic.
    function automatic logic [63:0] ref_step(input logic [63:0] r, input logic [63:0] d,
                                             input logic [63:0] tap, input int w, input bit mode);
        logic [63:0] m;
        logic        fb;
        m = (64'd1 << w) - 64'd1;
        if (!mode) return d & m;
        fb = ~(^(r & tap));
        return (((r << 1) | {63'd0, fb}) ^ d) & m;
    endfunction

    function automatic logic [NB-1:0] rand_word();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[NB-1:0];
    endfunction

    function automatic logic [NC*NB-1:0] rep_seed(input logic [NB-1:0] s);
        return {NC{s}};
    endfunction

    // Hand-derived 4-bit run: seed 0, four zero beats on ch0, done on the fourth.
    task automatic run_small(input logic [7:0] golden, input logic [1:0] exp_pass, input string tag);
        logic [3:0] steps [4];
        steps = '{4'h1, 4'h3, 4'h7, 4'hE};
        bus_b.i_golden = golden;
        bus_b.i_start  = 1'b1;
        tick();
        bus_b.i_start  = 1'b0;
        check_eq({tag, "_busy"}, 256'(bus_b.o_busy), 256'(1'b1));
        for (int k = 0; k < 4; k++) begin
            bus_b.i_vld  = 2'b01;
            bus_b.i_data = '0;
            bus_b.i_done = (k == 3);
            tick();
            check_eq($sformatf("%s_step%0d", tag, k), 256'(bus_b.o_sig), 256'({4'h0, steps[k]}));
        end
        bus_b.i_vld  = '0;
        bus_b.i_done = 1'b0;
        check_eq({tag, "_cnt"},      256'(bus_b.o_cnt),      256'(8'h04));
        check_eq({tag, "_sigvld"},   256'(bus_b.o_sig_vld),  256'(2'b11));
        check_eq({tag, "_pass"},     256'(bus_b.o_pass),     256'(exp_pass));
        check_eq({tag, "_allpass"},  256'(bus_b.o_all_pass), 256'(&exp_pass));
        check_eq({tag, "_busy_end"}, 256'(bus_b.o_busy),     256'(1'b0));
        // HOLD ignores further beats and done pulses.
        bus_b.i_vld  = 2'b11;
        bus_b.i_data = 8'hA5;
        bus_b.i_done = 1'b1;
        tick();
        bus_b.i_vld  = '0;
        bus_b.i_done = 1'b0;
        check_eq({tag, "_sigvld_once"}, 256'(bus_b.o_sig_vld),  256'(2'b00));
        check_eq({tag, "_hold_sig"},    256'(bus_b.o_sig),      256'({4'h0, 4'hE}));
        check_eq({tag, "_hold_cnt"},    256'(bus_b.o_cnt),      256'(8'h04));
        check_eq({tag, "_hold_all"},    256'(bus_b.o_all_pass), 256'(&exp_pass));
    endtask

    // Random signature run on the default instance, expectations folded from a beat list.
    task automatic run_sig(input int run_id);
        logic [NB-1:0]    seed;
        logic [NB-1:0]    e_sig [NC];
        int               e_cnt [NC];
        logic [NC-1:0]    q_vld [$];
        logic [NC*NB-1:0] q_dat [$];
        logic [NC*NB-1:0] e_sig_p;
        logic [NC*CW-1:0] e_cnt_p;
        logic [NC*NB-1:0] golden;
        logic [NC-1:0]    e_pass;
        logic [NC*NB-1:0] d;
        int               nbeats;
        seed   = rand_word();
        nbeats = $urandom_range(1, 20);
        for (int k = 0; k < nbeats; k++) begin
            for (int c = 0; c < NC; c++) d[c*NB +: NB] = rand_word();
            q_vld.push_back(NC'($urandom()));
            q_dat.push_back(d);
        end
        for (int c = 0; c < NC; c++) begin
            e_sig[c] = seed;
            e_cnt[c] = 0;
            for (int k = 0; k < nbeats; k++) begin
                if (q_vld[k][c]) begin
                    e_sig[c] = NB'(ref_step(64'(e_sig[c]), 64'(q_dat[k][c*NB +: NB]), 64'(TAP), NB, 1'b1));
                    e_cnt[c]++;
                end
            end
            e_sig_p[c*NB +: NB] = e_sig[c];
            e_cnt_p[c*CW +: CW] = CW'(e_cnt[c]);
        end
        golden = e_sig_p;
        if (run_id % 2 == 0) golden[$urandom_range(0, NC*NB-1)] ^= 1'b1;
        for (int c = 0; c < NC; c++) e_pass[c] = (golden[c*NB +: NB] == e_sig[c]);

        bus_a.i_mode   = 1'b1;
        bus_a.i_seed   = seed;
        bus_a.i_golden = golden;
        bus_a.i_start  = 1'b1;
        tick();
        bus_a.i_start  = 1'b0;
        check_eq($sformatf("sig%0d_seed", run_id), 256'(bus_a.o_sig), 256'(rep_seed(seed)));
        for (int k = 0; k < nbeats; k++) begin
            bus_a.i_vld  = q_vld[k];
            bus_a.i_data = q_dat[k];
            bus_a.i_done = (k == nbeats - 1);
            tick();
            if (k < nbeats - 1) begin
                check_eq($sformatf("sig%0d_busy%0d", run_id, k), 256'({bus_a.o_busy, bus_a.o_sig_vld}),
                         256'({1'b1, {NC{1'b0}}}));
            end
        end
        bus_a.i_vld  = '0;
        bus_a.i_done = 1'b0;
        check_eq($sformatf("sig%0d_sig", run_id),     256'(bus_a.o_sig),      256'(e_sig_p));
        check_eq($sformatf("sig%0d_cnt", run_id),     256'(bus_a.o_cnt),      256'(e_cnt_p));
        check_eq($sformatf("sig%0d_sigvld", run_id),  256'(bus_a.o_sig_vld),  256'({NC{1'b1}}));
        check_eq($sformatf("sig%0d_pass", run_id),    256'(bus_a.o_pass),     256'(e_pass));
        check_eq($sformatf("sig%0d_allpass", run_id), 256'(bus_a.o_all_pass), 256'(&e_pass));
        check_eq($sformatf("sig%0d_busy", run_id),    256'(bus_a.o_busy),     256'(1'b0));
        tick();
        check_eq($sformatf("sig%0d_vldoff", run_id),  256'(bus_a.o_sig_vld),  256'(0));
        check_eq($sformatf("sig%0d_frozen", run_id),  256'(bus_a.o_sig),      256'(e_sig_p));
    endtask

    initial begin
        logic [NB-1:0]    seed;
        logic [NB-1:0]    seed2;
        logic [NB-1:0]    e_sig [NC];
        int               e_cnt [NC];
        logic [NC*NB-1:0] e_sig_p;
        logic [NC*CW-1:0] e_cnt_p;
        logic [NC-1:0]    prev_vld;
        logic [NC*NB-1:0] d;
        logic [63:0]      pat;
        int               sat;

        bus_a.i_mode = 1'b1; bus_a.i_start = 1'b0; bus_a.i_done = 1'b0;
        bus_a.i_vld = '0; bus_a.i_data = '0; bus_a.i_golden = '0;
        bus_b.i_mode = 1'b1; bus_b.i_start = 1'b0; bus_b.i_done = 1'b0;
        bus_b.i_vld = '0; bus_b.i_data = '0; bus_b.i_golden = '0; bus_b.i_seed = '0;
        seed = rand_word();
        bus_a.i_seed = seed;

        // Reset followed by idle cycles.
        rst_a = 1'b1; rst_b = 1'b1;
        tick();
        rst_a = 1'b0; rst_b = 1'b0;
        bus_a.i_seed = ~seed;
        repeat (5) tick();
        check_eq("rst_sig",     256'(bus_a.o_sig),      256'(rep_seed(seed)));
        check_eq("rst_busy",    256'(bus_a.o_busy),     256'(1'b0));
        check_eq("rst_sigvld",  256'(bus_a.o_sig_vld),  256'(0));
        check_eq("rst_cnt",     256'(bus_a.o_cnt),      256'(0));
        check_eq("rst_pass",    256'({bus_a.o_pass, bus_a.o_all_pass}), 256'(0));
        check_eq("rst_b_sig",   256'(bus_b.o_sig),      256'(0));

        // Small configuration: matching golden, then golden with ch0 bit 0 flipped.
        run_small(8'h0E, 2'b11, "small_ok");
        run_small(8'h0F, 2'b10, "small_bad");

        // Counter saturation on the 4-bit counter instance.
        bus_b.i_start = 1'b1;
        tick();
        bus_b.i_start = 1'b0;
        for (int k = 0; k < (1 << SCW) + 3; k++) begin
            bus_b.i_vld  = 2'b11;
            bus_b.i_data = 8'($urandom());
            bus_b.i_done = (k == (1 << SCW) + 2);
            tick();
            sat = (k + 1 > 15) ? 15 : k + 1;
            check_eq($sformatf("sat_cnt%0d", k), 256'(bus_b.o_cnt), 256'({4'(sat), 4'(sat)}));
        end
        bus_b.i_vld = '0; bus_b.i_done = 1'b0;
        check_eq("sat_sigvld", 256'(bus_b.o_sig_vld), 256'(2'b11));

        // Random signature runs, alternating matching and corrupted golden.
        for (int r = 0; r < 6; r++) run_sig(r);

        // Bypass capture: directed beat then random beats.
        seed = rand_word();
        bus_a.i_mode  = 1'b0;
        bus_a.i_seed  = seed;
        bus_a.i_start = 1'b1;
        tick();
        bus_a.i_start = 1'b0;
        for (int c = 0; c < NC; c++) begin e_sig[c] = seed; e_cnt[c] = 0; end
        for (int k = 0; k < 16; k++) begin
            if (k == 0) begin
                d = '0;
                pat = 64'hA5A5_A5A5_A5A5_A5A5; d[0*NB +: NB] = pat[NB-1:0];
                pat = 64'h1234_5678_9ABC_DEF0; d[2*NB +: NB] = pat[NB-1:0];
                prev_vld = 4'b0101;
            end else begin
                for (int c = 0; c < NC; c++) d[c*NB +: NB] = rand_word();
                prev_vld = NC'($urandom());
            end
            bus_a.i_vld  = prev_vld;
            bus_a.i_data = d;
            bus_a.i_done = (k == 15);
            for (int c = 0; c < NC; c++) begin
                if (prev_vld[c]) begin
                    e_sig[c] = NB'(ref_step(64'(e_sig[c]), 64'(d[c*NB +: NB]), 64'(TAP), NB, 1'b0));
                    e_cnt[c]++;
                end
                e_sig_p[c*NB +: NB] = e_sig[c];
                e_cnt_p[c*CW +: CW] = CW'(e_cnt[c]);
            end
            tick();
            check_eq($sformatf("byp_sig%0d", k),    256'(bus_a.o_sig),     256'(e_sig_p));
            check_eq($sformatf("byp_sigvld%0d", k), 256'(bus_a.o_sig_vld), 256'(prev_vld));
        end
        bus_a.i_vld = '0; bus_a.i_done = 1'b0;
        check_eq("byp_cnt",     256'(bus_a.o_cnt),      256'(e_cnt_p));
        check_eq("byp_pass",    256'(bus_a.o_pass),     256'(0));
        check_eq("byp_allpass", 256'(bus_a.o_all_pass), 256'(1'b0));
        check_eq("byp_busy",    256'(bus_a.o_busy),     256'(1'b0));
        tick();
        check_eq("byp_vldoff",  256'(bus_a.o_sig_vld),  256'(0));

        // Start together with done while running: restart with the new seed.
        seed  = rand_word();
        seed2 = rand_word();
        bus_a.i_mode  = 1'b1;
        bus_a.i_seed  = seed;
        bus_a.i_start = 1'b1;
        tick();
        bus_a.i_start = 1'b0;
        repeat (3) begin
            bus_a.i_vld  = '1;
            for (int c = 0; c < NC; c++) d[c*NB +: NB] = rand_word();
            bus_a.i_data = d;
            tick();
        end
        bus_a.i_seed  = seed2;
        bus_a.i_start = 1'b1;
        bus_a.i_done  = 1'b1;
        tick();
        bus_a.i_start = 1'b0; bus_a.i_done = 1'b0; bus_a.i_vld = '0;
        check_eq("sd_busy",   256'(bus_a.o_busy),    256'(1'b1));
        check_eq("sd_sig",    256'(bus_a.o_sig),     256'(rep_seed(seed2)));
        check_eq("sd_cnt",    256'(bus_a.o_cnt),     256'(0));
        check_eq("sd_sigvld", 256'(bus_a.o_sig_vld), 256'(0));
        tick();
        check_eq("sd_still",  256'({bus_a.o_busy, bus_a.o_sig_vld}), 256'({1'b1, {NC{1'b0}}}));
        bus_a.i_golden = rep_seed(seed2);
        bus_a.i_done   = 1'b1;
        tick();
        bus_a.i_done   = 1'b0;
        check_eq("sd_finish", 256'({bus_a.o_sig_vld, bus_a.o_all_pass}), 256'({{NC{1'b1}}, 1'b1}));

        // Reset in the middle of a run.
        seed = rand_word();
        bus_a.i_seed  = seed;
        bus_a.i_start = 1'b1;
        tick();
        bus_a.i_start = 1'b0;
        repeat (10) begin
            bus_a.i_vld  = '1;
            for (int c = 0; c < NC; c++) d[c*NB +: NB] = rand_word();
            bus_a.i_data = d;
            tick();
        end
        seed2 = rand_word();
        bus_a.i_seed = seed2;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        bus_a.i_vld = '0;
        check_eq("mrst_busy",   256'(bus_a.o_busy),     256'(1'b0));
        check_eq("mrst_sig",    256'(bus_a.o_sig),      256'(rep_seed(seed2)));
        check_eq("mrst_cnt",    256'(bus_a.o_cnt),      256'(0));
        check_eq("mrst_sigvld", 256'(bus_a.o_sig_vld),  256'(0));
        bus_a.i_done = 1'b1;
        tick();
        bus_a.i_done = 1'b0;
        check_eq("mrst_idle",   256'({bus_a.o_busy, bus_a.o_sig_vld, bus_a.o_all_pass}), 256'(0));
        check_eq("mrst_hold",   256'(bus_a.o_sig),      256'(rep_seed(seed2)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
